pipe_ctrl: RTL and testbench

Central pipeline sequencer for the RISC-V-lite core. It drives the enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and handles four cases: load-use stalls, taken-branch redirect and flush, data-memory wait states with a timeout, and a post-reset pipeline scrub. It sits beside the datapath. It reads hazard information from the ID/EX/MEM stages and the data-memory handshake, and produces only control.

---
 rtl/pipe_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for load-use stalls, branch flushes, DMEM wait states and reset scrub.
// Optional performance counters are built only when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl #(
    parameter int DMEM_TIMEOUT = 15,
    parameter int INIT_CYCLES  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_mem_to_reg_i,
    input  logic        mem_branch_i,
    input  logic        mem_zero_i,
    input  logic        mem_access_i,
    input  logic        dmem_ack_i,
    output logic        dmem_req_o,
    output logic        pc_en_o,
    output logic        pc_sel_o,
    output logic        if_id_en_o,
    output logic        id_ex_en_o,
    output logic        ex_mem_en_o,
    output logic        mem_wb_en_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_flush_o,
    output logic        timeout_err_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    localparam int CNT_MAX = (DMEM_TIMEOUT > INIT_CYCLES) ? DMEM_TIMEOUT : INIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_DMEM_WAIT
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic load_use;
    logic branch_taken;
    logic mem_stall;
    logic at_timeout;
    logic forced_release;
    logic run_rules;
    logic branch_flush;

    // rd = x0 is never a real producer, so it cannot create a load-use hazard.
    assign load_use = ex_mem_to_reg_i && (ex_rd_addr_i != 5'd0) &&
                      ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

    assign branch_taken   = mem_branch_i && mem_zero_i;
    assign mem_stall      = mem_access_i && !dmem_ack_i;
    assign at_timeout     = (cnt == CNT_W'(DMEM_TIMEOUT));
    assign forced_release = (state == ST_DMEM_WAIT) && !dmem_ack_i && at_timeout;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        next_state     = state;
        cnt_next       = cnt;
        run_rules      = 1'b0;
        branch_flush   = 1'b0;
        dmem_req_o     = 1'b0;
        pc_en_o        = 1'b1;
        pc_sel_o       = 1'b0;
        if_id_en_o     = 1'b1;
        id_ex_en_o     = 1'b1;
        ex_mem_en_o    = 1'b1;
        mem_wb_en_o    = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;

        case (state)
            ST_INIT: begin
                pc_en_o        = 1'b0;
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
                if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
                    cnt_next   = '0;
                    next_state = ST_RUN;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                dmem_req_o = mem_access_i;
                if (mem_stall) begin
                    pc_en_o     = 1'b0;
                    if_id_en_o  = 1'b0;
                    id_ex_en_o  = 1'b0;
                    ex_mem_en_o = 1'b0;
                    mem_wb_en_o = 1'b0;
                    cnt_next    = CNT_W'(1);
                    next_state  = ST_DMEM_WAIT;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_DMEM_WAIT: begin
                dmem_req_o = 1'b1;
                // Ack wins over a simultaneous timeout; either way the release cycle behaves like RUN.
                if (dmem_ack_i || at_timeout) begin
                    run_rules  = 1'b1;
                    cnt_next   = '0;
                    next_state = ST_RUN;
                end else begin
                    pc_en_o     = 1'b0;
                    if_id_en_o  = 1'b0;
                    id_ex_en_o  = 1'b0;
                    ex_mem_en_o = 1'b0;
                    mem_wb_en_o = 1'b0;
                    cnt_next    = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = ST_INIT;
                cnt_next   = '0;
            end
        endcase

        if (run_rules) begin
            if (branch_taken) begin
                pc_sel_o       = 1'b1;
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
                branch_flush   = 1'b1;
            end else if (load_use) begin
                pc_en_o       = 1'b0;
                if_id_en_o    = 1'b0;
                id_ex_flush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            timeout_err_o <= 1'b0;
        end else if (forced_release) begin
            timeout_err_o <= 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Scrub cycles are not stalls, so INIT is excluded from the stall count.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state != ST_INIT) && !pc_en_o) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (branch_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven and sequence checks of pipe_ctrl with a scoreboard of expected controls.
// Counter expectations follow PIPE_CTRL_PERF_CNT_EN (zero when it is not defined).
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control bundle order: dmem_req, pc_en, pc_sel, if_id/id_ex/ex_mem/mem_wb enables, if_id/id_ex/ex_mem flushes.
    localparam logic [9:0] CTRL_RUN     = 10'b0_1_0_1111_000;
    localparam logic [9:0] CTRL_RUN_ACC = 10'b1_1_0_1111_000;
    localparam logic [9:0] CTRL_LU      = 10'b0_0_0_0111_010;
    localparam logic [9:0] CTRL_LU_ACC  = 10'b1_0_0_0111_010;
    localparam logic [9:0] CTRL_BR      = 10'b0_1_1_1111_111;
    localparam logic [9:0] CTRL_INIT    = 10'b0_0_0_1111_111;
    localparam logic [9:0] CTRL_FROZEN  = 10'b1_0_0_0000_000;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
        logic [4:0] ex_rd;
        logic       ex_load;
        logic       branch;
        logic       zero;
        logic       access;
        logic       ack;
        logic [9:0] exp_ctrl;
    } vec_t;

    logic        clk;
    logic        rst_i;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  ex_rd_addr;
    logic        ex_mem_to_reg;
    logic        mem_branch;
    logic        mem_zero;
    logic        mem_access;
    logic        dmem_ack;
    logic        dmem_req;
    logic        pc_en;
    logic        pc_sel;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        timeout_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int          checks;
    int          failures;
    int unsigned exp_stall;
    int unsigned exp_flush;
    logic [9:0]  sb_ctrl[$];
    string       sb_name[$];
    vec_t        tbl[12];
    vec_t        idle;
    vec_t        init_v;
    vec_t        acc_wait;
    vec_t        acc_ack;

    wire [9:0] act_ctrl = {dmem_req, pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                           if_id_flush, id_ex_flush, ex_mem_flush};

    pipe_ctrl #(.DMEM_TIMEOUT(15), .INIT_CYCLES(2)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .id_rs1_addr_i   (id_rs1_addr),
        .id_rs2_addr_i   (id_rs2_addr),
        .id_rs1_used_i   (id_rs1_used),
        .id_rs2_used_i   (id_rs2_used),
        .ex_rd_addr_i    (ex_rd_addr),
        .ex_mem_to_reg_i (ex_mem_to_reg),
        .mem_branch_i    (mem_branch),
        .mem_zero_i      (mem_zero),
        .mem_access_i    (mem_access),
        .dmem_ack_i      (dmem_ack),
        .dmem_req_o      (dmem_req),
        .pc_en_o         (pc_en),
        .pc_sel_o        (pc_sel),
        .if_id_en_o      (if_id_en),
        .id_ex_en_o      (id_ex_en),
        .ex_mem_en_o     (ex_mem_en),
        .mem_wb_en_o     (mem_wb_en),
        .if_id_flush_o   (if_id_flush),
        .id_ex_flush_o   (id_ex_flush),
        .ex_mem_flush_o  (ex_mem_flush),
        .timeout_err_o   (timeout_err),
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got=running want=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic [4:0] rd, input logic ld,
                                input logic br, input logic z, input logic acc, input logic ack,
                                input logic [9:0] exp_ctrl);
        vec_t v;
        v.rs1      = rs1;
        v.rs2      = rs2;
        v.rs1_used = u1;
        v.rs2_used = u2;
        v.ex_rd    = rd;
        v.ex_load  = ld;
        v.branch   = br;
        v.zero     = z;
        v.access   = acc;
        v.ack      = ack;
        v.exp_ctrl = exp_ctrl;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_rs1_addr   = v.rs1;
        id_rs2_addr   = v.rs2;
        id_rs1_used   = v.rs1_used;
        id_rs2_used   = v.rs2_used;
        ex_rd_addr    = v.ex_rd;
        ex_mem_to_reg = v.ex_load;
        mem_branch    = v.branch;
        mem_zero      = v.zero;
        mem_access    = v.access;
        dmem_ack      = v.ack;
    endtask

    // Expected counter effects are taken from the expected controls, not from the DUT.
    task automatic push_expected(input string name, input logic [9:0] exp_ctrl);
        sb_ctrl.push_back(exp_ctrl);
        sb_name.push_back(name);
        if (PERF && exp_ctrl != CTRL_INIT && !exp_ctrl[8]) exp_stall++;
        if (PERF && exp_ctrl[7]) exp_flush++;
    endtask

    task automatic apply_stimulus(input string name, input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        push_expected(name, v.exp_ctrl);
    endtask

    task automatic check_output();
        logic [9:0] exp_ctrl;
        string      name;
        @(negedge clk);
        if (sb_ctrl.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty: got=0 entries want=1");
        end else begin
            exp_ctrl = sb_ctrl.pop_front();
            name     = sb_name.pop_front();
            check_val(name, {22'd0, act_ctrl}, {22'd0, exp_ctrl});
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        apply_stimulus(name, v);
        check_output();
    endtask

    task automatic check_counters(input string tag);
        check_val({tag, "_stall_cnt"}, stall_cnt, exp_stall);
        check_val({tag, "_flush_cnt"}, flush_cnt, exp_flush);
    endtask

    // Holds an access until the wait reaches its 15th cycle, then applies the release vector.
    task automatic wait_15(input string tag, input vec_t release_v);
        run_vec({tag, "_enter"}, acc_wait);
        for (int i = 1; i < 15; i++) begin
            run_vec($sformatf("%s_wait%0d", tag, i), acc_wait);
        end
        run_vec({tag, "_release"}, release_v);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_stall = 0;
        exp_flush = 0;

        idle     = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTRL_RUN);
        init_v   = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTRL_INIT);
        acc_wait = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CTRL_FROZEN);
        acc_ack  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, CTRL_RUN_ACC);

        tbl[0]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTRL_RUN);
        tbl[1]  = mk(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTRL_LU);
        tbl[2]  = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTRL_RUN);
        tbl[3]  = mk(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTRL_LU);
        tbl[4]  = mk(5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTRL_RUN);
        tbl[5]  = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTRL_RUN);
        tbl[6]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, CTRL_BR);
        tbl[7]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CTRL_RUN);
        tbl[8]  = mk(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, CTRL_BR);
        tbl[9]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, CTRL_RUN_ACC);
        tbl[10] = mk(5'd9, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, CTRL_LU_ACC);
        tbl[11] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CTRL_RUN);

        // Reset held from time zero: INIT controls without any clock edge.
        rst_i = 1'b0;
        drive(idle);
        #3;
        check_val("reset_ctrl", {22'd0, act_ctrl}, {22'd0, CTRL_INIT});
        check_val("reset_timeout_err", {31'd0, timeout_err}, 32'd0);
        check_counters("reset");

        // Scrub: two INIT cycles after release, then RUN.
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        push_expected("scrub_cycle1", CTRL_INIT);
        check_output();
        run_vec("scrub_cycle2", init_v);
        run_vec("scrub_run", idle);

        // Memory wait with ack on the fourth frozen cycle.
        run_vec("memwait_enter", acc_wait);
        for (int i = 1; i < 4; i++) begin
            run_vec($sformatf("memwait_frozen%0d", i), acc_wait);
        end
        run_vec("memwait_ack", acc_ack);
        run_vec("memwait_after", idle);
        check_counters("memwait");

        $display("[TB] applying %0d table vectors", $size(tbl));
        for (int i = 0; i < $size(tbl); i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i]);
        end
        run_vec("tbl_after", idle);
        check_counters("table");

        // Ack on the 15th wait cycle coincides with the timeout and must count as an ack.
        wait_15("ack15", acc_ack);
        run_vec("ack15_after", idle);
        check_val("ack15_timeout_err", {31'd0, timeout_err}, 32'd0);
        check_counters("ack15");

        // Ack never arrives: forced release and a sticky error flag.
        wait_15("timeout", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CTRL_RUN_ACC));
        check_val("timeout_err_before_edge", {31'd0, timeout_err}, 32'd0);
        run_vec("timeout_after", idle);
        check_val("timeout_err_set", {31'd0, timeout_err}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            run_vec($sformatf("timeout_idle%0d", i), idle);
        end
        check_val("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
        check_counters("timeout");

        // Reset in the middle of a wait abandons the access immediately.
        run_vec("midwait_enter", acc_wait);
        run_vec("midwait_frozen", acc_wait);
        #2;
        rst_i = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        #1;
        check_val("midwait_reset_ctrl", {22'd0, act_ctrl}, {22'd0, CTRL_INIT});
        check_val("midwait_reset_dmem_req", {31'd0, dmem_req}, 32'd0);
        check_val("midwait_reset_timeout_err", {31'd0, timeout_err}, 32'd0);
        check_counters("midwait_reset");
        check_val("scoreboard_drained", sb_ctrl.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
